mul_issue_controller: RTL

Execute-stage control block for RISC-V M-extension multiplies (MUL, MULH, MULHSU, MULHU). It sits directly upstream of the 32x32 unsigned integer multiplication unit and feeds it. It accepts a decoded multiply op, converts signed operands to magnitudes and issues them to the multiplier. After a fixed latency it captures the 64-bit product, restores the sign, selects the low or high word and holds the result for writeback under a valid/ready handshake.

---
 rtl/mul_issue_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mul_issue_controller.sv
// mul_issue_controller
// Execute-stage control for RV32M multiplies (MUL, MULH, MULHSU, MULHU).
// Converts signed operands to magnitudes and issues them to a fixed-latency
// 32x32 unsigned multiplier. It then captures the 64-bit product, restores
// the sign, selects the low or high word and holds the result for writeback
// under a valid/ready handshake.

module mul_issue_controller #(
    parameter int MUL_LATENCY = 3,   // enable-to-product cycles, >= 1
    parameter int TAG_W       = 5    // destination register tag width
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // Decoded multiply op from issue
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       rs1_i,
    input  logic [31:0]       rs2_i,
    input  logic [TAG_W-1:0]  rd_i,
    input  logic              flush_i,

    // Multiplier interface
    output logic              mul_enable_o,
    output logic [31:0]       mul_operand1_o,
    output logic [31:0]       mul_operand2_o,
    input  logic [63:0]       mul_product_i,

    // Writeback interface
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [31:0]       wb_data_o,
    output logic [TAG_W-1:0]  wb_rd_o
);

    // Counter must hold MUL_LATENCY itself, so size it for MUL_LATENCY+1 values.
    localparam int CNT_W = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for an op
        ST_WAIT = 2'd1,   // multiply in flight, counter running
        ST_DONE = 2'd2    // result held for writeback
    } state_t;

    // funct3[1:0] encodings; funct3[2] is not part of the op select.
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                is_mul_q;   // select low word of the product
    logic                negate_q;   // s1 ^ s2 of the op in flight
    logic [TAG_W-1:0]    rd_q;       // tag of the op in flight

    // ------------------------------------------------------------------
    // Combinational decode / datapath
    // ------------------------------------------------------------------
    mul_op_t             op;
    logic                sign1;
    logic                sign2;
    logic [31:0]         mag1;
    logic [31:0]         mag2;
    logic [63:0]         product_signed;
    logic [31:0]         result_word;
    logic                issue_fire;
    logic                wb_fire;

    // Handshakes: flush_i is the only input with a combinational path out.
    assign issue_ready_o = (state_q == ST_IDLE) && !flush_i;
    assign wb_valid_o    = (state_q == ST_DONE) && !flush_i;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign wb_fire       = wb_valid_o && wb_ready_i;

    // Decode the incoming op and form operand magnitudes for the unsigned multiplier.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op    = mul_op_t'(funct3_i[1:0]);
        sign1 = 1'b0;
        sign2 = 1'b0;
        case (op)
            OP_MULH: begin
                sign1 = rs1_i[31];
                sign2 = rs2_i[31];
            end
            OP_MULHSU: begin
                sign1 = rs1_i[31];
            end
            default: begin
                // MUL and MULHU feed raw operands: the low word of MUL is
                // sign-independent and MULHU is fully unsigned.
            end
        endcase
        // Negating 0x80000000 yields 0x80000000, its correct unsigned magnitude.
        mag1 = sign1 ? (~rs1_i + 32'd1) : rs1_i;
        mag2 = sign2 ? (~rs2_i + 32'd1) : rs2_i;
    end

    // Restore the sign of the full 64-bit product and select the result word.
    always_comb begin
        product_signed = negate_q ? (~mul_product_i + 64'd1) : mul_product_i;
        result_word    = is_mul_q ? product_signed[31:0] : product_signed[63:32];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered multiplier and writeback outputs
    // ------------------------------------------------------------------

    // Single sequential block: reset beats flush, flush beats every handshake.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            // NOTE: the datapath registers are reset too, so outputs read as zero after reset, not stale data.
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_ZERO;
            is_mul_q       <= 1'b0;
            negate_q       <= 1'b0;
            rd_q           <= '0;
            mul_enable_o   <= 1'b0;
            mul_operand1_o <= 32'd0;
            mul_operand2_o <= 32'd0;
            wb_data_o      <= 32'd0;
            wb_rd_o        <= '0;
        end else if (flush_i) begin
            // Squash whatever is in flight. A product still coming out of
            // the multiplier is never sampled, because only WAIT captures.
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            mul_enable_o <= 1'b0;
        end else begin
            // Start pulse lasts exactly one cycle unless re-armed below.
            mul_enable_o <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (issue_fire) begin
                        state_q        <= ST_WAIT;
                        cnt_q          <= CNT_LOAD;
                        is_mul_q       <= (op == OP_MUL);
                        negate_q       <= sign1 ^ sign2;
                        rd_q           <= rd_i;
                        mul_operand1_o <= mag1;
                        mul_operand2_o <= mag2;
                        mul_enable_o   <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    // Operands stay untouched here, so they are stable for the
                    // whole multiply. The product is valid once the count hits zero.
                    if (cnt_q == CNT_ZERO) begin
                        state_q   <= ST_DONE;
                        wb_data_o <= result_word;
                        wb_rd_o   <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_DONE: begin
                    // Result and tag hold until writeback takes them. The
                    // return to IDLE means no issue can coincide with this handshake.
                    if (wb_fire) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule
